// File: rtl/sram_bank_if.sv
// sram_bank_if -- request/response bundle for sram_bank.
//   cs, we, be, ad, din : request from the master (chip select, write enable,
//                         byte enables, word address, write data)
//   dout, rvalid        : registered read data and its one-cycle valid pulse
//   busy                : high while the bank is clearing itself after reset
interface sram_bank_if #(
    parameter int WIDTH     = 32,
    parameter int DEPTH_LOG = 4
);
    localparam int BE_W = WIDTH / 8;

    logic                 cs;
    logic                 we;
    logic [BE_W-1:0]      be;
    logic [DEPTH_LOG-1:0] ad;
    logic [WIDTH-1:0]     din;
    logic [WIDTH-1:0]     dout;
    logic                 rvalid;
    logic                 busy;

    modport master (output cs, we, be, ad, din, input dout, rvalid, busy);
    modport slave  (input cs, we, be, ad, din, output dout, rvalid, busy);
endinterface

// File: rtl/sram_bank.sv
// sram_bank -- single-port word memory with byte-lane writes, registered
// reads (1 or 2 cycles latency) and a self-clearing sweep after reset.
//   clk    : clock, all state changes on its rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : sram_bank_if.slave (cs/we/be/ad/din in; dout/rvalid/busy out)
// After reset the bank writes zero to every word, one per cycle, holding busy
// high; requests are ignored until that sweep has finished.
module sram_bank #(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 32,
    parameter int RD_LAT    = 1,
    parameter int DEPTH_LOG = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    sram_bank_if.slave  bus
);
    localparam int BE_W = WIDTH / 8;
    localparam logic [DEPTH_LOG-1:0] LAST_ADDR = DEPTH_LOG'(DEPTH - 1);
    localparam logic [DEPTH_LOG:0]   DEPTH_W   = (DEPTH_LOG + 1)'(DEPTH);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [DEPTH_LOG-1:0] cnt_q, cnt_d;
    logic                 busy;

    logic                 in_range;
    logic                 wr_acc;
    logic                 rd_acc;

    logic                 mem_we;
    logic [DEPTH_LOG-1:0] mem_addr;
    logic [WIDTH-1:0]     mem_wdata;
    logic [BE_W-1:0]      mem_be;
    logic [WIDTH-1:0]     mem [DEPTH];
    logic [WIDTH-1:0]     rd_word;

    logic                 out_vld;
    logic [WIDTH-1:0]     out_data;
    logic [WIDTH-1:0]     dout_q, dout_d;
    logic                 rvalid_q, rvalid_d;

    // Clear sweep state machine: CLEAR walks the counter over every word once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                busy = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Addresses past the last word (non-power-of-2 depth) are never stored to
    // and read back as zero.
    assign in_range = ({1'b0, bus.ad} < DEPTH_W);
    assign wr_acc   = bus.cs & bus.we & ~busy & in_range;
    assign rd_acc   = bus.cs & ~bus.we & ~busy;
    assign rd_word  = in_range ? mem[bus.ad] : '0;

    // The single write port is shared: the sweep owns it while busy.
    always_comb begin
        mem_we    = wr_acc;
        mem_addr  = bus.ad;
        mem_wdata = bus.din;
        mem_be    = bus.be;
        if (busy) begin
            mem_we    = 1'b1;
            mem_addr  = cnt_q;
            mem_wdata = '0;
            mem_be    = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read pipeline. With two cycles of latency the word is captured in an
    // intermediate register at the accepting edge, so a later write to the
    // same address cannot disturb the data already in flight.
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic             s1_vld_q, s1_vld_d;
            logic [WIDTH-1:0] s1_data_q, s1_data_d;

            always_comb begin
                s1_vld_d  = rd_acc;
                s1_data_d = s1_data_q;
                if (rd_acc) begin
                    s1_data_d = rd_word;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_vld_q  <= 1'b0;
                    s1_data_q <= '0;
                end else begin
                    s1_vld_q  <= s1_vld_d;
                    s1_data_q <= s1_data_d;
                end
            end

            assign out_vld  = s1_vld_q;
            assign out_data = s1_data_q;
        end else begin : g_lat1
            assign out_vld  = rd_acc;
            assign out_data = rd_word;
        end
    endgenerate

    // dout only moves when a read completes; writes never touch it.
    always_comb begin
        rvalid_d = out_vld;
        dout_d   = out_vld ? out_data : dout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_CLEAR;
            cnt_q    <= '0;
            dout_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.dout   = dout_q;
    assign bus.rvalid = rvalid_q;
    assign bus.busy   = busy;
endmodule

// File: tb/tb_sram_bank.sv
// tb_sram_bank -- three banks driven by the same request stream:
//   u0: DEPTH=16 RD_LAT=1, u1: DEPTH=16 RD_LAT=2, u2: DEPTH=12 RD_LAT=1.
// A word-array model per bank predicts busy, rvalid and dout every cycle.
module tb_sram_bank;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [3:0]  ad = '0;
    logic [31:0] din = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_bank_if #(.WIDTH(32), .DEPTH_LOG(4)) if0 ();
    sram_bank_if #(.WIDTH(32), .DEPTH_LOG(4)) if1 ();
    sram_bank_if #(.WIDTH(32), .DEPTH_LOG(4)) if2 ();

    assign if0.cs = cs;  assign if0.we = we;  assign if0.be = be;  assign if0.ad = ad;  assign if0.din = din;
    assign if1.cs = cs;  assign if1.we = we;  assign if1.be = be;  assign if1.ad = ad;  assign if1.din = din;
    assign if2.cs = cs;  assign if2.we = we;  assign if2.be = be;  assign if2.ad = ad;  assign if2.din = din;

    sram_bank #(.DEPTH(16), .WIDTH(32), .RD_LAT(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    sram_bank #(.DEPTH(16), .WIDTH(32), .RD_LAT(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    sram_bank #(.DEPTH(12), .WIDTH(32), .RD_LAT(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    logic [31:0] o_dout [3];
    logic        o_rv   [3];
    logic        o_busy [3];
    assign o_dout[0] = if0.dout;  assign o_rv[0] = if0.rvalid;  assign o_busy[0] = if0.busy;
    assign o_dout[1] = if1.dout;  assign o_rv[1] = if1.rvalid;  assign o_busy[1] = if1.busy;
    assign o_dout[2] = if2.dout;  assign o_rv[2] = if2.rvalid;  assign o_busy[2] = if2.busy;

    // Reference model
    int          lat [3] = '{1, 2, 1};
    int          dep [3] = '{16, 16, 12};
    logic [31:0] m   [3][16];
    int          bl  [3];          // busy cycles remaining
    bit          pv  [3];          // read issued last cycle (latency 2 only)
    logic [31:0] pd  [3];
    bit          erv [3];
    logic [31:0] edout [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_u%0d_rvalid", tag, i), {31'b0, o_rv[i]}, {31'b0, erv[i]});
            chk($sformatf("%s_u%0d_dout", tag, i), o_dout[i], edout[i]);
            chk($sformatf("%s_u%0d_busy", tag, i), {31'b0, o_busy[i]}, {31'b0, (bl[i] != 0)});
        end
    endtask

    // One clock of stimulus; called #1 after a rising edge.
    task automatic do_cycle(input bit c, input bit w, input logic [3:0] b,
                            input logic [3:0] a, input logic [31:0] d);
        bit          acc;
        bit          rd;
        logic [31:0] rdata;
        cs = c; we = w; be = b; ad = a; din = d;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            acc   = c && (bl[i] == 0);
            rd    = acc && !w;
            rdata = (int'(a) < dep[i]) ? m[i][a] : 32'h0;
            if (acc && w && int'(a) < dep[i]) begin
                for (int l = 0; l < 4; l++) begin
                    if (b[l]) m[i][a][8*l +: 8] = d[8*l +: 8];
                end
            end
            if (lat[i] == 1) begin
                erv[i] = rd;
                if (rd) edout[i] = rdata;
            end else begin
                erv[i] = pv[i];
                if (pv[i]) edout[i] = pd[i];
                pv[i] = rd;
                pd[i] = rdata;
            end
            if (bl[i] > 0) bl[i]--;
        end
        #1;
        $display("cyc cs=%0b we=%0b be=%h ad=%0d din=%h | rv=%0b%0b%0b dout0=%h dout1=%h dout2=%h busy=%0b",
                 c, w, b, a, d, o_rv[0], o_rv[1], o_rv[2], o_dout[0], o_dout[1], o_dout[2], o_busy[0]);
        check_all("cyc");
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) do_cycle(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    // Assert reset away from the edge, check the asynchronous effect, then release.
    task automatic do_reset();
        cs = 1'b0; we = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            bl[i] = dep[i];
            pv[i] = 1'b0;
            erv[i] = 1'b0;
            edout[i] = 32'h0;
            for (int j = 0; j < 16; j++) m[i][j] = 32'h0;
        end
        check_all("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic count_busy(input int start_n);
        int n = start_n;
        while (n < 40 && o_busy[0]) begin
            idle(1);
            n++;
        end
        chk("busy_len", n, 16);
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();

        // Requests while clearing are ignored, then busy lasts 16 cycles.
        do_cycle(1'b1, 1'b1, 4'hF, 4'd2, 32'h0000_00FF);
        do_cycle(1'b1, 1'b0, 4'hF, 4'd2, 32'h0);
        count_busy(2);

        // Every word reads back zero.
        for (int a = 0; a < 16; a++) do_cycle(1'b1, 1'b0, 4'h0, 4'(a), 32'h0);
        idle(2);

        // Byte-lane merge.
        do_cycle(1'b1, 1'b1, 4'hF, 4'd3, 32'hAABB_CCDD);
        do_cycle(1'b1, 1'b1, 4'h5, 4'd3, 32'h1122_3344);
        do_cycle(1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
        idle(1);
        chk("merge_u0", o_dout[0], 32'hAA22_CC44);
        chk("merge_u1", o_dout[1], 32'hAA22_CC44);

        // Back-to-back reads.
        for (int a = 0; a < 3; a++) do_cycle(1'b1, 1'b1, 4'hF, 4'(a), 32'h10 + 32'(a));
        for (int a = 0; a < 3; a++) do_cycle(1'b1, 1'b0, 4'h0, 4'(a), 32'h0);
        chk("b2b_u1_last", o_dout[1], 32'h11);
        idle(2);

        // Write behind an in-flight read, then read-after-write.
        do_cycle(1'b1, 1'b1, 4'hF, 4'd5, 32'h5);
        do_cycle(1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
        do_cycle(1'b1, 1'b1, 4'hF, 4'd5, 32'h9);
        chk("inflight_u1", o_dout[1], 32'h5);
        do_cycle(1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
        idle(1);
        chk("raw_u1", o_dout[1], 32'h9);

        // Zero byte enables store nothing; out-of-range address on the 12-word bank.
        do_cycle(1'b1, 1'b1, 4'h0, 4'd5, 32'hDEAD_BEEF);
        do_cycle(1'b1, 1'b1, 4'hF, 4'd13, 32'h1357_9BDF);
        do_cycle(1'b1, 1'b0, 4'h0, 4'd13, 32'h0);
        do_cycle(1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
        idle(2);

        // Randomized traffic, biased towards a few hot addresses.
        for (int k = 0; k < 300; k++) begin
            do_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom),
                     ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15)),
                     $urandom);
        end
        idle(2);

        // Reset with a read in flight on the two-cycle bank.
        do_cycle(1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
        do_reset();
        idle(7);
        // Reset mid-sweep with the counter at 7.
        do_reset();
        count_busy(0);

        for (int k = 0; k < 60; k++) begin
            do_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom),
                     4'($urandom_range(0, 15)), $urandom);
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sram_bank.md
SRAM_BANK -- requirements
Module: sram_bank

Interface
REQ-001 Parameter DEPTH, default 16: number of words; any value >= 2.
REQ-002 Parameter WIDTH, default 32: word width in bits; SHALL be a multiple of 8.
REQ-003 Parameter RD_LAT, default 1: read latency in cycles; legal values 1 or 2.
REQ-004 Parameter DEPTH_LOG, default $clog2(DEPTH): address width.
REQ-005 Derived BE_W = WIDTH/8: byte-lane count.
REQ-006 clk  input  1  single clock; all state updates on posedge clk.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 cs  input  1  chip select; request valid when high.
REQ-009 we  input  1  write enable; 1 = write, 0 = read (qualified by cs).
REQ-010 be  input  BE_W  byte enables for writes; bit i covers din[8i+7:8i].
REQ-011 ad  input  DEPTH_LOG  word address.
REQ-012 din  input  WIDTH  write data.
REQ-013 dout  output  WIDTH  registered read data.
REQ-014 rvalid  output  1  one-cycle pulse marking new dout.
REQ-015 busy  output  1  high while the post-reset clear sweep runs; requests ignored.

Function
REQ-016 FSM states CLEAR and IDLE; CLEAR -> IDLE after the write to word DEPTH-1; IDLE is held until reset.
REQ-017 CLEAR: internal counter starts at 0 and writes all-zero to mem[counter] each cycle, incrementing by 1; sweep lasts exactly DEPTH cycles.
REQ-018 busy = 1 in CLEAR and 0 in IDLE; cs/we/be/ad/din are ignored while busy = 1 (no write, no rvalid).
REQ-019 Write accepted when cs=1, we=1, busy=0: for every i with be[i]=1, mem[ad] lane i <= din lane i at that edge; lanes with be[i]=0 are unchanged.
REQ-020 Write with be = 0 changes no storage and has no other effect.
REQ-021 Read accepted when cs=1, we=0, busy=0 (be ignored): mem[ad] is sampled at the accepting edge.
REQ-022 RD_LAT=1: dout and rvalid=1 updated at the accepting edge, visible the following cycle.
REQ-023 RD_LAT=2: sampled data passes one extra register stage; dout and rvalid=1 appear one cycle later than for RD_LAT=1.
REQ-024 Back-to-back reads, one per cycle, SHALL be supported at full throughput for both latencies; rvalid stays high for consecutive cycles.
REQ-025 rvalid = 0 in any cycle with no read completing; dout holds its last read value (writes never change dout).
REQ-026 Read-after-write: a read in the cycle after a write to the same address returns the new data.
REQ-027 A write issued while a read to the same address is in flight (RD_LAT=2) SHALL NOT alter that read's returned data.
REQ-028 Address >= DEPTH (non-power-of-2 DEPTH): write ignored; read returns all-zero with rvalid=1 at normal latency.
REQ-029 cs=0: no storage change, no rvalid, dout held.

Reset
REQ-030 rst_n=0 asynchronously forces: state CLEAR, counter 0, dout 0, rvalid 0, read pipeline emptied, busy 1.
REQ-031 The clear sweep starts on the first posedge clk with rst_n=1; busy falls DEPTH cycles later.
REQ-032 Reset asserted mid-sweep or mid-read restarts the sweep from word 0; in-flight reads are discarded with no rvalid.
REQ-033 Storage contents are defined (all zero) only once busy has fallen.

Verification
REQ-034 Release rst_n, DEPTH=16 -> busy=1 for exactly 16 cycles then 0; reads of all 16 addresses return 0 with rvalid pulses.
REQ-035 Write ad=3 din=0xAABBCCDD be=4'b1111, then write ad=3 din=0x11223344 be=4'b0101, read ad=3 -> dout=0xAA22CC44.
REQ-036 RD_LAT=2: reads of ad=0,1,2 on consecutive cycles after preloading 0x10,0x11,0x12 -> rvalid high 3 consecutive cycles starting 2 cycles after first request, data in order.
REQ-037 RD_LAT=2: read ad=5 (holds 0x5), write ad=5 din=0x9 next cycle -> returned data 0x5; subsequent read -> 0x9.
REQ-038 cs=1, we=1, ad=2, din=0xFF while busy=1 -> after sweep, read ad=2 returns 0; no rvalid during busy.
REQ-039 Assert rst_n=0 mid-sweep at counter=7 and with a read in flight -> dout=0, rvalid=0 immediately; busy stays 1 for full 16 cycles after release.
